// File: rtl/jtag_tap_master.sv
`default_nettype none
// ============================================================================
//  Module      : jtag_tap_master
//  Description : Host-side JTAG initiator. Accepts TAP-reset, IR-scan,
//                DR-scan and idle-clock commands, walks the TAP from
//                Run-Test/Idle through the scan and back, and returns the
//                TDO bits captured during the shift.
//  Revision    : 1.0 - initial release
// ============================================================================
module jtag_tap_master #(
    parameter int CLK_DIV = 4,
    parameter int MAX_LEN = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [1:0]                   cmd_type,
    input  logic [$clog2(MAX_LEN+1)-1:0] cmd_len,
    input  logic [MAX_LEN-1:0]           cmd_data,
    output logic                         rsp_valid,
    output logic [MAX_LEN-1:0]           rsp_data,
    output logic                         busy,
    output logic                         jtag_tck,
    output logic                         jtag_tms,
    output logic                         jtag_tdi,
    input  logic                         jtag_tdo
);

    // Length field width, TCK index width (longest command is MAX_LEN+6 TCKs),
    // data bit index width and TCK half-period divider width.
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int CW = $clog2(MAX_LEN + 7);
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [1:0]    TYPE_RST  = 2'b00;
    localparam logic [1:0]    TYPE_IR   = 2'b01;
    localparam logic [1:0]    TYPE_DR   = 2'b10;
    localparam logic [1:0]    TYPE_IDLE = 2'b11;
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // What a single TCK slot drives: TMS, TDI, and whether it is a shift bit
    // (and which data bit it carries).
    typedef struct packed {
        logic          shift;
        logic          tms;
        logic          tdi;
        logic [IW-1:0] bit_idx;
    } slot_t;

    state_t            r_state;
    logic [1:0]        r_type;
    logic [LW-1:0]     r_len;
    logic [CW-1:0]     r_total;
    logic [CW-1:0]     r_idx;
    logic [MAX_LEN-1:0] r_data;
    logic [MAX_LEN-1:0] r_cap;
    logic [DW-1:0]     r_div;
    logic              r_cur_shift;
    logic [IW-1:0]     r_cur_bit;

    logic [LW-1:0]     w_len_clamp;
    logic [LW-1:0]     w_len_eff;
    logic [CW-1:0]     w_total;
    logic [CW-1:0]     w_nxt_idx;
    logic              w_last;
    slot_t             w_nxt;

    // Slot k of a command: scans are a fixed preamble (4 TCKs for IR, 3 for
    // DR), n shift bits with TMS=1 on the last one, then Update and RTI.
    function automatic slot_t slot_at(
        input logic [CW-1:0]      k,
        input logic [1:0]         typ,
        input logic [LW-1:0]      n,
        input logic [MAX_LEN-1:0] data
    );
        slot_t         s;
        logic [CW-1:0] pre;
        logic [CW-1:0] off;
        logic [CW-1:0] nn;
        s   = '0;
        nn  = CW'(n);
        pre = (typ == TYPE_IR) ? CW'(4) : CW'(3);
        off = k - pre;
        case (typ)
            TYPE_RST: s.tms = (k < CW'(5));
            TYPE_IR, TYPE_DR: begin
                if (k < pre) begin
                    s.tms = (typ == TYPE_IR) ? (k < CW'(2)) : (k == '0);
                end else if (off < nn) begin
                    s.shift   = 1'b1;
                    s.bit_idx = off[IW-1:0];
                    s.tms     = (off == nn - CW'(1));
                    s.tdi     = data[off[IW-1:0]];
                end else begin
                    s.tms = (off == nn);
                end
            end
            default: s.tms = 1'b0;
        endcase
        return s;
    endfunction

    // Decode the incoming command: clamp the length, force scans to at least
    // one bit, and work out how many TCKs the whole command takes.
    always_comb begin
        w_len_clamp = (cmd_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : cmd_len;
        w_len_eff   = w_len_clamp;
        w_total     = '0;
        case (cmd_type)
            TYPE_RST: w_total = CW'(6);
            TYPE_IR: begin
                if (w_len_clamp == '0) w_len_eff = LW'(1);
                w_total = CW'(w_len_eff) + CW'(6);
            end
            TYPE_DR: begin
                if (w_len_clamp == '0) w_len_eff = LW'(1);
                w_total = CW'(w_len_eff) + CW'(5);
            end
            default: w_total = CW'(w_len_clamp);
        endcase
    end

    // Slot to be driven at the next TCK falling edge (slot 0 from SETUP).
    always_comb begin
        w_nxt_idx = (r_state == S_RUN) ? (r_idx + CW'(1)) : '0;
        w_last    = (r_idx == (r_total - CW'(1)));
        w_nxt     = slot_at(w_nxt_idx, r_type, r_len, r_data);
    end

    // Command sequencer: handshake, TCK phase timing, TMS/TDI drive, TDO capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_type      <= TYPE_RST;
            r_len       <= '0;
            r_total     <= '0;
            r_idx       <= '0;
            r_data      <= '0;
            r_cap       <= '0;
            r_div       <= '0;
            r_cur_shift <= 1'b0;
            r_cur_bit   <= '0;
            cmd_ready   <= 1'b1;
            busy        <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            jtag_tck    <= 1'b0;
            jtag_tms    <= 1'b1;
            jtag_tdi    <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        r_type    <= cmd_type;
                        r_len     <= w_len_eff;
                        r_total   <= w_total;
                        r_data    <= cmd_data;
                        r_cap     <= '0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        r_state   <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_idx <= '0;
                    r_div <= '0;
                    if (r_total == '0) begin
                        // Zero-length idle command: nothing to clock out.
                        rsp_valid <= 1'b1;
                        rsp_data  <= '0;
                        r_state   <= S_DONE;
                    end else begin
                        // First LOW phase starts now with slot 0 on TMS/TDI.
                        jtag_tms    <= w_nxt.tms;
                        jtag_tdi    <= w_nxt.tdi;
                        r_cur_shift <= w_nxt.shift;
                        r_cur_bit   <= w_nxt.bit_idx;
                        r_state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (r_div != DIV_LAST) begin
                        r_div <= r_div + DW'(1);
                    end else begin
                        r_div <= '0;
                        if (!jtag_tck) begin
                            // End of LOW phase: rising edge, sample TDO.
                            jtag_tck <= 1'b1;
                            if (r_cur_shift) r_cap[r_cur_bit] <= jtag_tdo;
                        end else begin
                            // End of HIGH phase: falling edge, next slot.
                            jtag_tck <= 1'b0;
                            if (w_last) begin
                                rsp_valid <= 1'b1;
                                rsp_data  <= r_cap;
                                r_state   <= S_DONE;
                            end else begin
                                r_idx       <= w_nxt_idx;
                                jtag_tms    <= w_nxt.tms;
                                jtag_tdi    <= w_nxt.tdi;
                                r_cur_shift <= w_nxt.shift;
                                r_cur_bit   <= w_nxt.bit_idx;
                            end
                        end
                    end
                end
                S_DONE: begin
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jtag_tap_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jtag_tap_master
//  Description : Self-checking bench for jtag_tap_master with a behavioural
//                TAP (1-bit IR, 32-bit DR) on the JTAG pins.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jtag_tap_master;

    localparam int CLK_DIV = 2;
    localparam int MAX_LEN = 32;
    localparam int LW      = $clog2(MAX_LEN + 1);
    localparam int HALF    = 5;
    localparam int TCK_PER = 4 * CLK_DIV * HALF;
    localparam int TCK_HI  = 2 * CLK_DIV * HALF;

    localparam logic [1:0] TYPE_RST  = 2'b00;
    localparam logic [1:0] TYPE_IR   = 2'b01;
    localparam logic [1:0] TYPE_DR   = 2'b10;
    localparam logic [1:0] TYPE_IDLE = 2'b11;

    localparam int TLR = 0,  RTI = 1,  SDRS = 2,  CDR = 3,  SDR = 4,  E1DR = 5,
                   PDR = 6,  E2DR = 7, UDR = 8,   SIRS = 9, CIR = 10, SIR = 11,
                   E1IR = 12, PIR = 13, E2IR = 14, UIR = 15;

    typedef struct {
        logic [1:0]    typ;
        logic [LW-1:0] len;
        logic [31:0]   data;
        logic [31:0]   pre;
        int            exp_tck;
        logic [31:0]   exp_rsp;
        int            sel;       // 0 none, 1 check IR, 2 check DR
        logic [31:0]   exp_reg;
    } vec_t;

    logic              clk;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_type;
    logic [LW-1:0]     cmd_len;
    logic [MAX_LEN-1:0] cmd_data;
    logic              rsp_valid;
    logic [MAX_LEN-1:0] rsp_data;
    logic              busy;
    logic              jtag_tck;
    logic              jtag_tms;
    logic              jtag_tdi;
    logic              jtag_tdo;

    int checks   = 0;
    int failures = 0;

    // TAP model and pin monitor state
    int          tap_st  = TLR;
    logic        ir      = 1'b0;
    logic [31:0] dr      = 32'h0;
    logic [31:0] dr_preload = 32'h0;
    int          cmd_seq = 0;
    int          mon_seq = 0;
    int          n_tck   = 0;
    logic [63:0] tms_bits = '0;
    logic [63:0] tdi_bits = '0;
    longint      last_rise = 0;
    int          per_bad = 0;
    int          hi_bad  = 0;
    int          rsp_cnt = 0;

    jtag_tap_master #(
        .CLK_DIV (CLK_DIV),
        .MAX_LEN (MAX_LEN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_type  (cmd_type),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .jtag_tck  (jtag_tck),
        .jtag_tms  (jtag_tms),
        .jtag_tdi  (jtag_tdi),
        .jtag_tdo  (jtag_tdo)
    );

    initial clk = 1'b0;
    always #HALF clk = ~clk;

    assign jtag_tdo = (tap_st == SDR) ? dr[0] : ((tap_st == SIR) ? ir : 1'b0);

    // Log every TCK rise, check its period, and step the TAP model.
    always @(posedge jtag_tck) begin
        if (mon_seq != cmd_seq) begin
            mon_seq  = cmd_seq;
            n_tck    = 0;
            tms_bits = '0;
            tdi_bits = '0;
        end else if (n_tck > 0 && ($time - last_rise) != longint'(TCK_PER)) begin
            per_bad++;
        end
        last_rise = $time;
        if (n_tck < 64) begin
            tms_bits[n_tck[5:0]] = jtag_tms;
            tdi_bits[n_tck[5:0]] = jtag_tdi;
        end
        n_tck++;
        case (tap_st)
            TLR:  tap_st = jtag_tms ? TLR  : RTI;
            RTI:  tap_st = jtag_tms ? SDRS : RTI;
            SDRS: tap_st = jtag_tms ? SIRS : CDR;
            CDR:  begin dr = dr_preload;           tap_st = jtag_tms ? E1DR : SDR; end
            SDR:  begin dr = {jtag_tdi, dr[31:1]}; tap_st = jtag_tms ? E1DR : SDR; end
            E1DR: tap_st = jtag_tms ? UDR  : PDR;
            PDR:  tap_st = jtag_tms ? E2DR : PDR;
            E2DR: tap_st = jtag_tms ? UDR  : SDR;
            UDR:  tap_st = jtag_tms ? SDRS : RTI;
            SIRS: tap_st = jtag_tms ? TLR  : CIR;
            CIR:  begin ir = 1'b1;     tap_st = jtag_tms ? E1IR : SIR; end
            SIR:  begin ir = jtag_tdi; tap_st = jtag_tms ? E1IR : SIR; end
            E1IR: tap_st = jtag_tms ? UIR  : PIR;
            PIR:  tap_st = jtag_tms ? E2IR : PIR;
            E2IR: tap_st = jtag_tms ? UIR  : SIR;
            UIR:  tap_st = jtag_tms ? SDRS : RTI;
            default: tap_st = TLR;
        endcase
    end

    // HIGH phase length of every TCK.
    always @(negedge jtag_tck) begin
        if (($time - last_rise) != longint'(TCK_HI)) hi_bad++;
    end

    // Count response pulses.
    always @(posedge clk) begin
        if (rsp_valid) rsp_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic int tcks_this_cmd();
        return (mon_seq == cmd_seq) ? n_tck : 0;
    endfunction

    task automatic wait_rsp(input string tag, output int lat, output bit got);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 2000) begin
            if (rsp_valid) got = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        check({tag, "_rsp_seen"}, 64'(got), 64'd1);
    endtask

    // Issue one command and check the handshake around it.
    task automatic run_cmd(input logic [1:0] typ, input logic [LW-1:0] len,
                           input logic [31:0] data, input string tag, output int lat);
        int rc0;
        bit got;
        rc0 = rsp_cnt;
        @(negedge clk);
        check({tag, "_ready_before"}, 64'(cmd_ready), 64'd1);
        cmd_seq++;
        cmd_valid = 1'b1;
        cmd_type  = typ;
        cmd_len   = len;
        cmd_data  = data;
        @(negedge clk);
        cmd_valid = 1'b0;
        check({tag, "_busy_after_accept"}, 64'(busy), 64'd1);
        wait_rsp(tag, lat, got);
        if (got) begin
            check({tag, "_tck_at_rsp"}, 64'(jtag_tck), 64'd0);
            check({tag, "_ready_at_rsp"}, 64'(cmd_ready), 64'd0);
        end
        @(negedge clk);
        check({tag, "_ready_after"}, 64'(cmd_ready), 64'd1);
        check({tag, "_busy_after"}, 64'(busy), 64'd0);
        check({tag, "_rsp_pulses"}, 64'(rsp_cnt - rc0), 64'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_tck"},       64'(jtag_tck),  64'd0);
        check({tag, "_tms"},       64'(jtag_tms),  64'd1);
        check({tag, "_tdi"},       64'(jtag_tdi),  64'd0);
        check({tag, "_ready"},     64'(cmd_ready), 64'd1);
        check({tag, "_busy"},      64'(busy),      64'd0);
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, "_rsp_data"},  64'(rsp_data),  64'd0);
    endtask

    initial begin
        vec_t vecs [9];
        int   lat;
        int   pb0;
        int   hb0;
        int   rc0;
        int   w;
        bit   got;

        vecs[0] = '{TYPE_RST,  6'd0,  32'h0000_0000, 32'h0000_0000,  6, 32'h0000_0000, 0, 32'h0};
        vecs[1] = '{TYPE_IR,   6'd1,  32'h0000_0001, 32'h0000_0000,  7, 32'h0000_0001, 1, 32'h1};
        vecs[2] = '{TYPE_DR,   6'd32, 32'hA5A5_1234, 32'hDEAD_BEEF, 37, 32'hDEAD_BEEF, 2, 32'hA5A5_1234};
        vecs[3] = '{TYPE_DR,   6'd8,  32'h0000_003C, 32'h0000_0081, 13, 32'h0000_0081, 2, 32'h3C00_0000};
        vecs[4] = '{TYPE_DR,   6'd40, 32'h1234_5678, 32'hCAFE_F00D, 37, 32'hCAFE_F00D, 2, 32'h1234_5678};
        vecs[5] = '{TYPE_IDLE, 6'd0,  32'hFFFF_FFFF, 32'h0000_0000,  0, 32'h0000_0000, 0, 32'h0};
        vecs[6] = '{TYPE_IDLE, 6'd3,  32'hFFFF_FFFF, 32'h0000_0000,  3, 32'h0000_0000, 0, 32'h0};
        vecs[7] = '{TYPE_DR,   6'd0,  32'h0000_0001, 32'h0000_0003,  6, 32'h0000_0001, 2, 32'h8000_0001};
        vecs[8] = '{TYPE_IR,   6'd4,  32'h0000_000A, 32'h0000_0000, 10, 32'h0000_0005, 1, 32'h1};

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_type  = 2'b00;
        cmd_len   = '0;
        cmd_data  = '0;
        repeat (3) @(negedge clk);
        check_reset_values("por");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            dr_preload = vecs[i].pre;
            pb0 = per_bad;
            hb0 = hi_bad;
            run_cmd(vecs[i].typ, vecs[i].len, vecs[i].data, $sformatf("v%0d", i), lat);
            check($sformatf("v%0d_tcks", i), 64'(tcks_this_cmd()), 64'(vecs[i].exp_tck));
            check($sformatf("v%0d_rsp_data", i), 64'(rsp_data), 64'(vecs[i].exp_rsp));
            check($sformatf("v%0d_tap_rti", i), 64'(tap_st), 64'(RTI));
            check($sformatf("v%0d_tck_period", i), 64'(per_bad - pb0), 64'd0);
            check($sformatf("v%0d_tck_high", i), 64'(hi_bad - hb0), 64'd0);
            if (vecs[i].sel == 1) check($sformatf("v%0d_ir", i), 64'(ir), 64'(vecs[i].exp_reg));
            if (vecs[i].sel == 2) check($sformatf("v%0d_dr", i), 64'(dr), 64'(vecs[i].exp_reg));
            if (vecs[i].exp_tck == 0) check($sformatf("v%0d_latency", i), 64'(lat), 64'd1);
        end

        // TAP reset TMS walk
        run_cmd(TYPE_RST, '0, 32'h0, "rst_walk", lat);
        check("rst_walk_tms", tms_bits, 64'h1F);
        check("rst_walk_tdi", tdi_bits, 64'h0);

        // Command presented while busy must be ignored
        rc0 = rsp_cnt;
        @(negedge clk);
        cmd_seq++;
        cmd_valid = 1'b1;
        cmd_type  = TYPE_IDLE;
        cmd_len   = 6'd3;
        cmd_data  = '0;
        @(negedge clk);
        cmd_type  = TYPE_RST;
        cmd_len   = '0;
        repeat (4) begin
            @(negedge clk);
            check("busy_ignore_ready", 64'(cmd_ready), 64'd0);
        end
        cmd_valid = 1'b0;
        wait_rsp("busy_ignore", lat, got);
        @(negedge clk);
        check("busy_ignore_tcks", 64'(tcks_this_cmd()), 64'd3);
        check("busy_ignore_pulses", 64'(rsp_cnt - rc0), 64'd1);
        check("busy_ignore_tap_rti", 64'(tap_st), 64'(RTI));

        // IR scan TMS/TDI walk (also leaves a non-zero response behind)
        run_cmd(TYPE_IR, 6'd1, 32'h1, "ir_walk", lat);
        check("ir_walk_tms", tms_bits, 64'h33);
        check("ir_walk_tdi", tdi_bits, 64'h10);
        check("ir_walk_rsp", 64'(rsp_data), 64'h1);

        // Asynchronous reset in the middle of a DR scan, at shift bit 10
        dr_preload = 32'h0F0F_0F0F;
        @(negedge clk);
        cmd_seq++;
        cmd_valid = 1'b1;
        cmd_type  = TYPE_DR;
        cmd_len   = 6'd32;
        cmd_data  = 32'hFFFF_FFFF;
        @(negedge clk);
        cmd_valid = 1'b0;
        w = 0;
        while (!((mon_seq == cmd_seq) && (n_tck >= 14)) && w < 500) begin
            @(negedge clk);
            w++;
        end
        check("midrst_reached_bit10", 64'(w < 500), 64'd1);
        check("midrst_tck_high_before", 64'(jtag_tck), 64'd1);
        check("midrst_tdi_before", 64'(jtag_tdi), 64'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_values("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_cmd(TYPE_RST, '0, 32'h0, "post_rst", lat);
        check("post_rst_tcks", 64'(tcks_this_cmd()), 64'd6);
        check("post_rst_tms", tms_bits, 64'h1F);
        check("post_rst_tap_rti", 64'(tap_st), 64'(RTI));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
